bw_seq_mult_ctrl: RTL and testbench

//  Sequential controller for a signed Baugh-Wooley multiplier. One partial-product
//  row per clock, using a single row of AW AND/NAND+full-adder cells.

---
 rtl/bw_seq_mult_ctrl_if.sv | 25 ++
 rtl/bw_seq_mult_ctrl.sv | 128 ++++++++++++
 tb/tb_bw_seq_mult_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bw_seq_mult_ctrl_if.sv
// Operand/product handshake bundle for the iterative Baugh-Wooley multiplier.
// The master drives operands and ack; the slave returns status and product.
interface bw_seq_mult_ctrl_if #(
   parameter int AW = 7,
   parameter int BW = 5
);
   logic              start;
   logic [AW-1:0]     a_in;
   logic [BW-1:0]     b_in;
   logic              ready;
   logic              busy;
   logic              valid;
   logic [AW+BW-1:0]  product;
   logic              ack;

   modport master (
      output start, a_in, b_in, ack,
      input  ready, busy, valid, product
   );

   modport slave (
      input  start, a_in, b_in, ack,
      output ready, busy, valid, product
   );
endinterface

// File: rtl/bw_seq_mult_ctrl.sv
// Iterative signed Baugh-Wooley multiplier: one partial-product row per clock,
// accumulated in carry-save form and resolved with the BW constant at the end.
module bw_seq_mult_ctrl #(
   parameter int AW = 7,
   parameter int BW = 5
) (
   input  logic              clk,
   input  logic              rst,
   bw_seq_mult_ctrl_if.slave bus
);
   localparam int PW = AW + BW;
   localparam int RW = $clog2(BW);
   localparam logic [PW-1:0] ONE      = PW'(1);
   localparam logic [PW-1:0] K_CORR   = (ONE << (PW-1)) | (ONE << (AW-1)) | (ONE << (BW-1));
   localparam logic [RW-1:0] ROW_LAST = RW'(BW-1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_r, state_nx_s;
   logic [AW-1:0]   a_r;
   logic [BW-1:0]   b_r;
   logic [RW-1:0]   row_r;
   logic [PW-1:0]   sum_r, carry_r, product_r;
   logic [PW-1:0]   pp_s, sum_nx_s, carry_nx_s;
   logic            ready_r, busy_r, valid_r;

   // Row j of the BW array: sign-row/sign-column cross terms are NANDed.
   function automatic logic [PW-1:0] bw_row(input logic [AW-1:0] a,
                                            input logic [BW-1:0] b,
                                            input logic [RW-1:0] j);
      logic [PW-1:0] r;
      logic          flip;
      r = {PW{1'b0}};
      for (int i = 0; i < AW; i++) begin
         flip = ((i == AW-1) != (int'(j) == BW-1));
         r[i] = (a[i] & b[j]) ^ flip;
      end
      return r << j;
   endfunction

   // One row of full adders folding the current partial product into sum/carry.
   always_comb begin
      pp_s       = bw_row(a_r, b_r, row_r);
      sum_nx_s   = sum_r ^ carry_r ^ pp_s;
      carry_nx_s = {(sum_r[PW-2:0] & carry_r[PW-2:0]) |
                    (sum_r[PW-2:0] & pp_s[PW-2:0])    |
                    (carry_r[PW-2:0] & pp_s[PW-2:0]), 1'b0};
   end

   // Next-state decode; start and ack only matter in IDLE and DONE respectively.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.start) state_nx_s = S_RUN;
            else           state_nx_s = S_IDLE;
         end
         S_RUN: begin
            if (row_r == ROW_LAST) state_nx_s = S_FIX;
            else                   state_nx_s = S_RUN;
         end
         S_FIX:  state_nx_s = S_DONE;
         S_DONE: begin
            if (bus.ack) state_nx_s = S_IDLE;
            else         state_nx_s = S_DONE;
         end
         default: state_nx_s = S_IDLE;
      endcase
   end

   // State register and status flags, registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         ready_r <= (state_nx_s == S_IDLE);
         busy_r  <= (state_nx_s == S_RUN) || (state_nx_s == S_FIX);
         valid_r <= (state_nx_s == S_DONE);
      end
   end

   // Operand capture, row accumulation and final product resolution.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r       <= {AW{1'b0}};
         b_r       <= {BW{1'b0}};
         row_r     <= {RW{1'b0}};
         sum_r     <= {PW{1'b0}};
         carry_r   <= {PW{1'b0}};
         product_r <= {PW{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  a_r     <= bus.a_in;
                  b_r     <= bus.b_in;
                  row_r   <= {RW{1'b0}};
                  sum_r   <= {PW{1'b0}};
                  carry_r <= {PW{1'b0}};
               end
            end
            S_RUN: begin
               sum_r   <= sum_nx_s;
               carry_r <= carry_nx_s;
               // Saturate so a stray extra cycle can never index a stale row.
               if (row_r != ROW_LAST) row_r <= row_r + ROW_ONE;
            end
            S_FIX: product_r <= sum_r + carry_r + K_CORR;
            default: ;
         endcase
      end
   end

   assign bus.ready   = ready_r;
   assign bus.busy    = busy_r;
   assign bus.valid   = valid_r;
   assign bus.product = product_r;
endmodule

// File: tb/tb_bw_seq_mult_ctrl.sv
// Directed and exhaustive checks of bw_seq_mult_ctrl against plain signed
// integer multiplication, with randomized operand noise and ack delays.
module tb_bw_seq_mult_ctrl;
   localparam int AW  = 7;
   localparam int BW  = 5;
   localparam int PW  = AW + BW;
   localparam int LAT = BW + 1;

   logic          clk;
   logic          rst;
   int            checks = 0;
   int            errors = 0;
   logic [PW-1:0] last_prod;

   bw_seq_mult_ctrl_if #(.AW(AW), .BW(BW)) bus ();

   bw_seq_mult_ctrl #(.AW(AW), .BW(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] ref_mult(input logic [AW-1:0] a, input logic [BW-1:0] b);
      int pa;
      int pb;
      pa = int'($signed(a));
      pb = int'($signed(b));
      return PW'(pa * pb);
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_ready"},   32'(bus.ready),   32'd1);
      check({tag, "_busy"},    32'(bus.busy),    32'd0);
      check({tag, "_valid"},   32'(bus.valid),   32'd0);
      check({tag, "_product"}, 32'(bus.product), 32'(last_prod));
   endtask

   // One full transaction; noisy keeps start high and scrambles operands throughout.
   task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input int hold, input bit noisy);
      logic [PW-1:0] exp_p;
      int            n;
      exp_p = ref_mult(a, b);
      check("ready_before_start", 32'(bus.ready), 32'd1);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      tick();
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      check("product_hold_run", 32'(bus.product), 32'(last_prod));
      n = 0;
      while (!bus.valid && n < 20) begin
         bus.a_in  = AW'($urandom);
         bus.b_in  = BW'($urandom);
         bus.start = noisy ? 1'b1 : 1'($urandom_range(0, 1));
         bus.ack   = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("latency", 32'(n), 32'(LAT));
      check("product", 32'(bus.product), 32'(exp_p));
      check("ready_in_done", 32'(bus.ready), 32'd0);
      bus.ack   = 1'b0;
      bus.start = noisy ? 1'b1 : 1'b0;
      for (int h = 0; h < hold; h++) begin
         bus.a_in = AW'($urandom);
         bus.b_in = BW'($urandom);
         tick();
         check("valid_hold", 32'(bus.valid), 32'd1);
         check("product_hold", 32'(bus.product), 32'(exp_p));
      end
      bus.ack = 1'b1;
      tick();
      bus.ack   = 1'b0;
      bus.start = 1'b0;
      last_prod = exp_p;
      check_idle("after_ack");
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [BW-1:0] rb;
      bus.start = 1'b0;
      bus.a_in  = 7'd0;
      bus.b_in  = 5'd0;
      bus.ack   = 1'b0;
      last_prod = 12'd0;
      rst       = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset");

      bus.ack = 1'b1;
      tick();
      tick();
      bus.ack = 1'b0;
      check_idle("ack_while_idle");

      run_op(7'h3F, 5'h0F, 10, 1'b0);
      run_op(7'h40, 5'h10, 0, 1'b0);
      run_op(7'h40, 5'h0F, 1, 1'b0);
      run_op(7'h7F, 5'h1F, 0, 1'b0);
      run_op(7'h00, 5'h10, 2, 1'b0);

      ra = AW'($urandom);
      rb = BW'($urandom);
      run_op(ra, rb, 3, 1'b1);
      run_op(7'h15, 5'h0B, 0, 1'b1);

      bus.start = 1'b1;
      bus.a_in  = 7'h3F;
      bus.b_in  = 5'h0F;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_prod = 12'd0;
      check_idle("reset_in_run");
      for (int i = 0; i < 8; i++) begin
         tick();
         check("no_valid_after_run_reset", 32'(bus.valid), 32'd0);
      end

      run_op(7'h21, 5'h13, 0, 1'b0);
      bus.start = 1'b1;
      bus.a_in  = 7'h55;
      bus.b_in  = 5'h1A;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < BW; i++) tick();
      check("busy_in_fix", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_prod = 12'd0;
      check_idle("reset_in_fix");
      for (int i = 0; i < 8; i++) begin
         tick();
         check("no_valid_after_fix_reset", 32'(bus.valid), 32'd0);
      end
      run_op(7'h55, 5'h1A, 1, 1'b0);

      for (int ai = 0; ai < 128; ai++) begin
         for (int bi = 0; bi < 32; bi++) begin
            run_op(AW'(ai), BW'(bi), int'($urandom_range(0, 3)), 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
